// File: rtl/e203_exu_disp_sched_if.sv
// Dispatch/retire bundle between decode-dispatch and the scheduler.
// master: dispatch + retire source; slave: scheduler (ready, itag, ret_err).
interface e203_exu_disp_sched_if #(
   parameter int ITAG_W  = 1,
   parameter int RFIDX_W = 5
);
   logic               disp_valid;
   logic               disp_ready;
   logic               disp_rs1en;
   logic               disp_rs2en;
   logic [RFIDX_W-1:0] disp_rs1idx;
   logic [RFIDX_W-1:0] disp_rs2idx;
   logic               disp_rdwen;
   logic [RFIDX_W-1:0] disp_rdidx;
   logic               disp_longpipe;
   logic [ITAG_W-1:0]  disp_itag;
   logic               ret_valid;
   logic [ITAG_W-1:0]  ret_itag;
   logic               ret_err;

   modport master (
      output disp_valid,
      output disp_rs1en,
      output disp_rs2en,
      output disp_rs1idx,
      output disp_rs2idx,
      output disp_rdwen,
      output disp_rdidx,
      output disp_longpipe,
      output ret_valid,
      output ret_itag,
      input  disp_ready,
      input  disp_itag,
      input  ret_err
   );

   modport slave (
      input  disp_valid,
      input  disp_rs1en,
      input  disp_rs2en,
      input  disp_rs1idx,
      input  disp_rs2idx,
      input  disp_rdwen,
      input  disp_rdidx,
      input  disp_longpipe,
      input  ret_valid,
      input  ret_itag,
      output disp_ready,
      output disp_itag,
      output ret_err
   );
endinterface

// File: rtl/e203_exu_disp_sched.sv
// Long-pipe dispatch scheduler: in-order ITAG table, RAW/WAW stall, halt drain.
// Ports: clk, rst_n (async low), bus (dispatch/retire, slave modport),
//   halt_req in, halt_ack/sched_empty/sched_full out, stall_cnt out (32b).
// Optional macro E203_DISP_SCHED_PERF_EN enables the hazard-stall counter;
//   without it stall_cnt is tied to zero.
module e203_exu_disp_sched #(
   parameter int DEPTH   = 2,
   parameter int ITAG_W  = 1,
   parameter int RFIDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   e203_exu_disp_sched_if.slave bus,
   input  logic                 halt_req,
   output logic                 halt_ack,
   output logic                 sched_empty,
   output logic                 sched_full,
   output logic [31:0]          stall_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [DEPTH-1:0]   ent_vld;
   logic [DEPTH-1:0]   ent_rdwen;
   logic [RFIDX_W-1:0] ent_rdidx [DEPTH];

   // Extra MSB is the wrap flag that separates full from empty.
   logic [ITAG_W:0]   wptr_q;
   logic [ITAG_W:0]   rptr_q;
   logic [ITAG_W-1:0] wptr;
   logic [ITAG_W-1:0] rptr;

   logic empty;
   logic full;
   logic fire;
   logic alloc;
   logic ret_ok;
   logic ret_err_q;
   logic halt_ack_q;

   logic hit1;
   logic hit2;
   logic hitw;
   logic raw1;
   logic raw2;
   logic waw;
   logic hazard;

   assign wptr  = wptr_q[ITAG_W-1:0];
   assign rptr  = rptr_q[ITAG_W-1:0];
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr == rptr)
                & (wptr_q[ITAG_W] != rptr_q[ITAG_W]);

   // Hazard looks only at registered entries; a retire
   // in the same cycle does not bypass.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      hitw = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i] && ent_rdwen[i]) begin
            if (ent_rdidx[i] == bus.disp_rs1idx)
               hit1 = 1'b1;
            if (ent_rdidx[i] == bus.disp_rs2idx)
               hit2 = 1'b1;
            if (ent_rdidx[i] == bus.disp_rdidx)
               hitw = 1'b1;
         end
      end
   end

   assign raw1 = bus.disp_rs1en
               & (|bus.disp_rs1idx) & hit1;
   assign raw2 = bus.disp_rs2en
               & (|bus.disp_rs2idx) & hit2;
   assign waw  = bus.disp_rdwen
               & (|bus.disp_rdidx) & hitw;
   assign hazard = raw1 | raw2 | waw;

   assign bus.disp_ready = (state_q == RUN)
                         & ~halt_req
                         & ~hazard
                         & ~(bus.disp_longpipe & full);

   assign fire  = bus.disp_valid & bus.disp_ready;
   assign alloc = fire & bus.disp_longpipe;

   assign ret_ok = bus.ret_valid & ~empty
                 & (bus.ret_itag == rptr);

   assign bus.disp_itag = wptr;
   assign bus.ret_err   = ret_err_q;
   assign halt_ack      = halt_ack_q;
   assign sched_empty   = empty;
   assign sched_full    = full;

   // Alloc and retire never target the same slot:
   // alloc needs !full and retire needs !empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_vld   <= '0;
         ent_rdwen <= '0;
         for (int i = 0; i < DEPTH; i++)
            ent_rdidx[i] <= '0;
      end else begin
         if (ret_ok)
            ent_vld[rptr] <= 1'b0;
         if (alloc) begin
            ent_vld[wptr]   <= 1'b1;
            ent_rdwen[wptr] <= bus.disp_rdwen;
            ent_rdidx[wptr] <= bus.disp_rdidx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (alloc)
            wptr_q <= wptr_q + (ITAG_W+1)'(1);
         if (ret_ok)
            rptr_q <= rptr_q + (ITAG_W+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ret_err_q <= 1'b0;
      else
         ret_err_q <= bus.ret_valid & ~ret_ok;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (halt_req)
               state_d = DRAIN;
         end
         DRAIN: begin
            if (!halt_req)
               state_d = RUN;
            else if (empty)
               state_d = HALTED;
         end
         HALTED: begin
            if (!halt_req)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         halt_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         halt_ack_q <= (state_d == HALTED);
      end
   end

`ifdef E203_DISP_SCHED_PERF_EN
   logic        stall_evt;
   logic [31:0] stall_q;

   assign stall_evt = bus.disp_valid & hazard
                    & (state_q == RUN) & ~halt_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_q <= '0;
      else if (stall_evt && !(&stall_q))
         stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
